// File: rtl/matvec_pkg.sv
// Shared types and elaboration helpers for the matrix-vector engine.
package matvec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CALC,
        DONE
    } state_t;

    // Accumulator width that can hold a full COLS-term dot product without wrapping.
    function automatic int min_acc_width(input int data_width, input int cols);
        return 2 * data_width + $clog2(cols);
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// One multiply-accumulate lane: acc += a*b when en, cleared by clr.
module matvec_mac
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    // One spare bit lets the unsigned product ride through the same signed multiplier.
    localparam int PW = 2 * DATA_WIDTH + 1;

    logic                 sa;
    logic                 sb;
    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] prod;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign sa   = SIGNED & a[DATA_WIDTH-1];
    assign sb   = SIGNED & b[DATA_WIDTH-1];
    assign a_x  = {{(PW-DATA_WIDTH){sa}}, a};
    assign b_x  = {{(PW-DATA_WIDTH){sb}}, b};
    assign prod = a_x * b_x;

    if (ACC_WIDTH > PW) begin : g_ext
        assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end else begin : g_trunc
        assign prod_ext = prod[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: fetches B then A rows over an Avalon-MM read
// master, then accumulates one column per cycle across ROWS parallel lanes.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   REQ   | read request for word wcnt, held while waitrequest
//   WAIT  | one read outstanding, waiting for readdatavalid
//   CALC  | accumulating column kcnt into every lane
//   DONE  | results valid and stable until the next accepted start
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 8,
    parameter int                    COLS       = 8,
    parameter int                    ACC_WIDTH  = 24,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter bit                    SIGNED     = 1'b0,
    localparam int                   IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    input  logic [DATA_WIDTH*COLS-1:0] mem_readdata,
    input  logic                       mem_readdatavalid,
    input  logic                       mem_waitrequest,
    input  logic [IDX_W-1:0]           res_idx,
    output logic [ACC_WIDTH-1:0]       res_data
);

    localparam int WCNT_W = $clog2(ROWS + 1);
    localparam int KCNT_W = (COLS > 1) ? $clog2(COLS) : 1;

    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, COLS)) begin : g_narrow_acc
        $warning("matvec_engine: ACC_WIDTH=%0d is below %0d, results may wrap",
                 ACC_WIDTH, min_acc_width(DATA_WIDTH, COLS));
    end

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  capture;
    logic                  last_word;
    logic                  calc_en;
    logic [WCNT_W-1:0]     wcnt;
    logic [KCNT_W-1:0]     kcnt;
    logic [DATA_WIDTH-1:0] b_reg [COLS];
    logic [DATA_WIDTH-1:0] a_reg [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc   [ROWS];

    assign capture   = (state == WAIT) && mem_readdatavalid;
    assign last_word = (wcnt == WCNT_W'(ROWS));
    assign calc_en   = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = REQ;
                    accept    = 1'b1;
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_readdatavalid) begin
                    state_nxt = last_word ? CALC : REQ;
                end
            end
            CALC: begin
                if (kcnt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == REQ) || (state == WAIT) || (state == CALC);
    assign done        = (state == DONE);
    assign mem_read    = (state == REQ);
    assign mem_address = (state == REQ) ? BASE_ADDR + ADDR_WIDTH'(wcnt) : '0;

    // Word counter walks B then the A rows; the column timer runs down to terminal count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            kcnt <= '0;
        end else begin
            if (accept) begin
                wcnt <= '0;
            end else if (capture && !last_word) begin
                wcnt <= wcnt + WCNT_W'(1);
            end

            if (capture && last_word) begin
                kcnt <= KCNT_W'(COLS - 1);
            end else if (calc_en && (kcnt != '0)) begin
                kcnt <= kcnt - KCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < COLS; k++) begin
                b_reg[k] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < COLS; k++) begin
                    a_reg[r][k] <= '0;
                end
            end
        end else if (capture) begin
            for (int k = 0; k < COLS; k++) begin
                if (wcnt == '0) begin
                    b_reg[k] <= mem_readdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int r = 0; r < ROWS; r++) begin
                    if (wcnt == WCNT_W'(r + 1)) begin
                        a_reg[r][k] <= mem_readdata[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Columns are consumed high-to-low; the sum is order independent.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        matvec_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (calc_en),
            .clr   (accept),
            .a     (a_reg[r][kcnt]),
            .b     (b_reg[kcnt]),
            .acc   (acc[r])
        );
    end

    always_comb begin
        res_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(res_idx) == r) begin
                res_data = acc[r];
            end
        end
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench for matvec_engine: table-driven runs on three
// parameterisations sharing one Avalon slave model, plus hand-written corner cases.
module tb_matvec_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef struct {
        string  nm;
        int     sel;
        int     lat;
        int     stall;
        int     mode;
        int     aval;
        int     bval;
        longint exp;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start0  = 1'b0;
    logic        start1  = 1'b0;
    logic        start2  = 1'b0;
    logic [2:0]  res_idx = '0;
    logic [63:0] rdata   = '0;
    logic        rdv     = 1'b0;
    logic        waitreq = 1'b0;

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        rd0, rd1, rd2;
    logic [31:0] addr0, addr1, addr2;
    logic [23:0] res0, res1;
    logic [15:0] res2;

    always #5 clk = ~clk;

    matvec_engine u_uns (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .mem_address(addr0), .mem_read(rd0), .mem_readdata(rdata),
        .mem_readdatavalid(rdv), .mem_waitrequest(waitreq),
        .res_idx(res_idx), .res_data(res0)
    );

    matvec_engine #(.SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .mem_address(addr1), .mem_read(rd1), .mem_readdata(rdata),
        .mem_readdatavalid(rdv), .mem_waitrequest(waitreq),
        .res_idx(res_idx), .res_data(res1)
    );

    matvec_engine #(.DATA_WIDTH(6), .ACC_WIDTH(16), .SIGNED(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .mem_address(addr2), .mem_read(rd2), .mem_readdata(rdata[47:0]),
        .mem_readdatavalid(rdv), .mem_waitrequest(waitreq),
        .res_idx(res_idx), .res_data(res2)
    );

    int sel        = 0;
    int lat        = 1;
    int stall      = 0;
    int stall_left = 0;
    int a_m [ROWS][COLS];
    int b_v [COLS];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int dw_of(input int s);
        return (s == 2) ? 6 : 8;
    endfunction

    function automatic int aw_of(input int s);
        return (s == 2) ? 16 : 24;
    endfunction

    function automatic logic cur_read();
        case (sel)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic int cur_addr();
        case (sel)
            0:       return int'(addr0);
            1:       return int'(addr1);
            default: return int'(addr2);
        endcase
    endfunction

    function automatic logic cur_busy();
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic cur_done();
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [23:0] cur_res();
        case (sel)
            0:       return res0;
            1:       return res1;
            default: return {8'h00, res2};
        endcase
    endfunction

    task automatic set_start(input logic v);
        case (sel)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // Memory image: word 0 holds B, word 1+r holds A row r, packed at the active element width.
    function automatic logic [63:0] pack_word(input int addr);
        logic [63:0] w;
        int dw;
        int val;
        w  = '0;
        dw = dw_of(sel);
        if (addr < 0 || addr > ROWS) return '0;
        for (int k = 0; k < COLS; k++) begin
            val = (addr == 0) ? b_v[k] : a_m[addr-1][k];
            for (int i = 0; i < dw; i++) begin
                w[k*dw + i] = val[i];
            end
        end
        return w;
    endfunction

    function automatic longint sx(input int v);
        int     dw;
        longint x;
        dw = dw_of(sel);
        x  = longint'(v) & ((longint'(1) << dw) - 1);
        if (sel != 0 && x >= (longint'(1) << (dw - 1))) x = x - (longint'(1) << dw);
        return x;
    endfunction

    function automatic longint model(input int r);
        longint s;
        s = 0;
        for (int k = 0; k < COLS; k++) begin
            s = s + sx(a_m[r][k]) * sx(b_v[k]);
        end
        return s & ((longint'(1) << aw_of(sel)) - 1);
    endfunction

    task automatic fill(input int mode, input int aval, input int bval);
        int dw;
        dw = dw_of(sel);
        for (int k = 0; k < COLS; k++) begin
            case (mode)
                0:       b_v[k] = bval;
                1:       b_v[k] = k + 1;
                default: b_v[k] = int'($urandom_range(0, (1 << dw) - 1));
            endcase
            for (int r = 0; r < ROWS; r++) begin
                case (mode)
                    0:       a_m[r][k] = aval;
                    1:       a_m[r][k] = (r == k) ? 1 : 0;
                    default: a_m[r][k] = int'($urandom_range(0, (1 << dw) - 1));
                endcase
            end
        end
    endtask

    // Avalon slave: W stall cycles per request, readdatavalid L cycles after acceptance.
    initial begin : slave
        bit pend;
        bit stalling;
        int cd;
        int pend_addr;
        int st_addr;
        pend = 0; stalling = 0; cd = 0; pend_addr = 0; st_addr = 0;
        forever begin
            @(negedge clk);
            rdv = 1'b0;
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    rdv   = 1'b1;
                    rdata = pack_word(pend_addr);
                    pend  = 0;
                end
            end
            if (!rst_n) begin
                waitreq  = 1'b0;
                stalling = 0;
            end else if (cur_read()) begin
                if (stall_left > 0) begin
                    waitreq = 1'b1;
                    if (stalling) chk("stall_addr", longint'(cur_addr()), longint'(st_addr));
                    else begin
                        stalling = 1;
                        st_addr  = cur_addr();
                    end
                    stall_left--;
                end else begin
                    if (stalling) chk("stall_release_addr", longint'(cur_addr()), longint'(st_addr));
                    waitreq    = 1'b0;
                    pend       = 1;
                    cd         = lat;
                    pend_addr  = cur_addr();
                    stall_left = stall;
                    stalling   = 0;
                end
            end else begin
                if (stalling) chk("stall_read_held", longint'(cur_read()), 1);
                stalling = 0;
                waitreq  = 1'b0;
            end
        end
    end

    task automatic start_run(input string nm);
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        stall_left = stall;
        chk({nm, "_busy_on_start"}, longint'(cur_busy()), 1);
        chk({nm, "_done_cleared"}, longint'(cur_done()), 0);
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (!cur_done() && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!cur_done()) chk({nm, "_done_timeout"}, longint'(cur_done()), 1);
    endtask

    task automatic check_results(input string nm, input int mode, input longint cexp);
        longint e;
        for (int r = 0; r < ROWS; r++) begin
            res_idx = 3'(r);
            #1;
            case (mode)
                0:       e = cexp;
                1:       e = longint'(r + 1);
                default: e = model(r);
            endcase
            chk($sformatf("%s_res%0d", nm, r), longint'(cur_res()), e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        sel   = v.sel;
        lat   = v.lat;
        stall = v.stall;
        fill(v.mode, v.aval, v.bval);
        start_run(v.nm);
        wait_done(v.nm, cyc);
        chk({v.nm, "_cycles"}, longint'(cyc), longint'(9 * (v.stall + v.lat + 1) + 8));
        chk({v.nm, "_busy_in_done"}, longint'(cur_busy()), 0);
        check_results(v.nm, v.mode, v.exp);
    endtask

    initial begin : main
        vec_t vt[$];
        int   cyc;

        //            name         sel lat stall mode aval bval exp
        vt.push_back('{"ident",     0,  1,  0,    1,   0,   0,   0});
        vt.push_back('{"all_ff",    0,  2,  0,    0,   255, 255, 520200});
        vt.push_back('{"ident_stl", 0,  3,  5,    1,   0,   0,   0});
        vt.push_back('{"sgn_m16",   1,  1,  0,    0,   255, 2,   24'hFFFFF0});
        vt.push_back('{"w16_m16",   2,  2,  1,    0,   63,  2,   16'hFFF0});
        vt.push_back('{"rnd_u0",    0,  1,  0,    2,   0,   0,   0});
        vt.push_back('{"rnd_u1",    0,  2,  2,    2,   0,   0,   0});
        vt.push_back('{"rnd_s0",    1,  1,  1,    2,   0,   0,   0});
        vt.push_back('{"rnd_s1",    1,  3,  0,    2,   0,   0,   0});
        vt.push_back('{"rnd_w0",    2,  1,  0,    2,   0,   0,   0});
        vt.push_back('{"rnd_w1",    2,  2,  2,    2,   0,   0,   0});

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_done", longint'(done0), 0);
        chk("rst_read", longint'(rd0), 0);
        chk("rst_addr", longint'(addr0), 0);
        check_results("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vt[i]) run_vec(vt[i]);

        // start pulses while busy are ignored; a start in DONE reruns from cleared accumulators
        sel = 0; lat = 1; stall = 0;
        fill(1, 0, 0);
        start_run("ign");
        cyc = 0;
        while (!done0 && cyc < 3000) begin
            start0 = (cyc == 3 || cyc == 21);
            @(posedge clk);
            #1;
            cyc++;
        end
        start0 = 1'b0;
        chk("ign_cycles", longint'(cyc), 26);
        check_results("ign", 1, 0);
        start_run("rerun");
        chk("rerun_acc_cleared", longint'(res0), 0);
        wait_done("rerun", cyc);
        chk("rerun_cycles", longint'(cyc), 26);
        check_results("rerun", 1, 0);

        // reset in the middle of CALC
        start_run("rst_calc");
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_calc_busy", longint'(busy0), 0);
        chk("rst_calc_done", longint'(done0), 0);
        chk("rst_calc_read", longint'(rd0), 0);
        chk("rst_calc_addr", longint'(addr0), 0);
        check_results("rst_calc", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // reset with a read outstanding; the late readdatavalid must not wake the engine
        lat = 3;
        start_run("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_busy", longint'(busy0), 0);
        chk("abort_done", longint'(done0), 0);
        chk("abort_read", longint'(rd0), 0);
        check_results("abort", 0, 0);

        run_vec('{"after_rst", 0, 1, 0, 1, 0, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
